// File: rtl/fp_custom_sqrt.sv
// rtl/fp_custom_sqrt.sv - iterative binary32 square root, one root bit per clock
// Feeds IQ magnitude from the I^2+Q^2 power stage; Busy_o throttles the producer.
module fp_custom_sqrt #(
  parameter int ManWidth = 23,
  parameter int ExpWidth = 8
) (
  input  logic                       Clk_i,
  input  logic                       Rst_i,
  input  logic                       Val_i,
  input  logic [ManWidth+ExpWidth:0] Data_i,
  output logic [ManWidth+ExpWidth:0] Result_o,
  output logic                       ResultVal_o,
  output logic                       Busy_o
);

  localparam int W    = ManWidth + ExpWidth + 1;
  localparam int N    = ManWidth + 2;
  localparam int RadW = 2 * N;
  localparam int RemW = N + 3;
  localparam int CntW = $clog2(N + 1);
  localparam int Bias = (1 << (ExpWidth - 1)) - 1;
  localparam logic [W-1:0] QNaN = {1'b0, {ExpWidth{1'b1}}, 1'b1, {(ManWidth-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, ROUND} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [RadW-1:0]     rad_q;
  logic [RemW-1:0]     rem_q;
  logic [N-1:0]        root_q;
  logic [ExpWidth-1:0] exp_q;
  logic                special_q;
  logic [W-1:0]        special_val_q;
  logic [W-1:0]        result_q;
  logic                res_val_q;
  logic                busy_q;

  assign Result_o    = result_q;
  assign ResultVal_o = res_val_q;
  assign Busy_o      = busy_q;

  // Operand preparation and classification
  logic                cap_sign;
  logic [ExpWidth-1:0] cap_expf;
  logic [ManWidth-1:0] cap_manf;
  logic [ExpWidth:0]   exp_sum;
  logic                e_odd;
  logic [ExpWidth-1:0] cap_exp;
  logic [N-1:0]        cap_mant;
  logic [RadW-1:0]     cap_rad;
  logic                cap_special;
  logic [W-1:0]        cap_spec_val;

  // (E + Bias) >> 1 equals floor((E - Bias) / 2) + Bias because 2*Bias is even;
  // the dropped LSB is exactly the parity of the unbiased exponent.
  always_comb begin
    cap_sign     = Data_i[W-1];
    cap_expf     = Data_i[W-2:ManWidth];
    cap_manf     = Data_i[ManWidth-1:0];
    exp_sum      = {1'b0, cap_expf} + (ExpWidth+1)'(Bias);
    e_odd        = exp_sum[0];
    cap_exp      = exp_sum[ExpWidth:1];
    cap_mant     = e_odd ? {1'b1, cap_manf, 1'b0} : {1'b0, 1'b1, cap_manf};
    cap_rad      = {cap_mant, {N{1'b0}}};
    cap_special  = 1'b1;
    cap_spec_val = QNaN;
    if (cap_expf == '0) begin
      cap_spec_val = {cap_sign, {(W-1){1'b0}}};
    end else if (&cap_expf) begin
      cap_spec_val = (!cap_sign && cap_manf == '0) ? Data_i : QNaN;
    end else if (!cap_sign) begin
      cap_special = 1'b0;
    end
  end

  // One restoring step: bring down two radicand bits, try (4*root + 1)
  logic [RemW-1:0] rem_sh;
  logic [RemW-1:0] trial;
  logic [RemW-1:0] rem_d;
  logic [N-1:0]    root_d;
  logic [RadW-1:0] rad_d;

  always_comb begin
    rem_sh = {rem_q[RemW-3:0], rad_q[RadW-1:RadW-2]};
    trial  = {1'b0, root_q, 2'b01};
    rad_d  = {rad_q[RadW-3:0], 2'b00};
    if (rem_sh >= trial) begin
      rem_d  = rem_sh - trial;
      root_d = {root_q[N-2:0], 1'b1};
    end else begin
      rem_d  = rem_sh;
      root_d = {root_q[N-2:0], 1'b0};
    end
  end

  // Rounding: root_q[0] is the guard bit, remainder gives sticky
  logic                sticky;
  logic                round_up;
  logic [N-1:0]        rnd_sum;
  logic                rnd_carry;
  logic [ManWidth-1:0] rnd_man;
  logic [ExpWidth-1:0] rnd_exp;

  always_comb begin
    sticky    = |rem_q;
    round_up  = root_q[0] & (sticky | root_q[1]);
    rnd_sum   = {1'b0, root_q[N-1:1]} + {{(N-1){1'b0}}, round_up};
    rnd_carry = rnd_sum[N-1];
    rnd_man   = rnd_carry ? rnd_sum[ManWidth:1] : rnd_sum[ManWidth-1:0];
    rnd_exp   = exp_q + {{(ExpWidth-1){1'b0}}, rnd_carry};
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rad_q         <= '0;
      rem_q         <= '0;
      root_q        <= '0;
      exp_q         <= '0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      result_q      <= '0;
      res_val_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      res_val_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Val_i) begin
            state_q       <= CALC;
            cnt_q         <= '0;
            rad_q         <= cap_rad;
            rem_q         <= '0;
            root_q        <= '0;
            exp_q         <= cap_exp;
            special_q     <= cap_special;
            special_val_q <= cap_spec_val;
            busy_q        <= 1'b1;
          end
        end
        CALC: begin
          rad_q  <= rad_d;
          rem_q  <= rem_d;
          root_q <= root_d;
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(N - 1)) begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          result_q  <= special_q ? special_val_q : {1'b0, rnd_exp, rnd_man};
          res_val_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fp_custom_sqrt.md
Name: fp_custom_sqrt

Overview:
- Iterative IEEE-754 binary32 square root; sits directly downstream of the I²+Q² power stage and turns its sum of squares into IQ magnitude.
- Data_i connects to the power stage's Result_o; Val_i connects to its ResultVal_o.
- Restoring digit-by-digit root, one root bit per clock; throughput is one operation per ManWidth+4 cycles, and Busy_o provides backpressure.

Parameters:
- ManWidth, 23, mantissa field width.
- ExpWidth, 8, exponent field width. Bias = 2^(ExpWidth-1)-1.

Ports:
- Clk_i  in  1  clock, rising edge.
- Rst_i  in  1  reset, asynchronous, active-high.
- Val_i  in  1  input valid; sampled only when the block is in IDLE.
- Data_i  in  ManWidth+ExpWidth+1  operand {sign, exp, man}.
- Result_o  out  ManWidth+ExpWidth+1  root; holds its value until the next result.
- ResultVal_o  out  1  one-cycle pulse, Result_o valid.
- Busy_o  out  1  high while an operation is in flight; Val_i is ignored while high.

Behaviour:
- Reset (async, Rst_i=1):
  - State returns to IDLE; iteration counter = 0.
  - Result_o = 0, ResultVal_o = 0, Busy_o = 0.
  - An in-flight operation is discarded; no ResultVal_o pulse follows reset release.
- FSM IDLE -> CALC -> ROUND -> IDLE, with N = ManWidth+2 iterations.
- IDLE:
  - At an edge with Val_i=1: capture the operand, classify it, go to CALC, set counter=0, set Busy_o=1.
  - Val_i=0 stays in IDLE.
- Operand preparation at capture:
  - Unbiased exponent e = E - Bias.
  - Radicand = {01.man}. If e is odd, shift the radicand left by 1 and use e-1.
  - Result exponent = e/2 + Bias (arithmetic shift).
- CALC:
  - Each edge produces one root bit via restoring subtraction on the remainder.
  - After N edges the state moves to ROUND.
  - Output is ManWidth+1 root bits (leading 1 included) plus 1 guard bit; sticky = (final remainder != 0).
- ROUND:
  - Round-to-nearest: add the guard bit to the root. A sqrt result is never exactly halfway, so this equals RNE.
  - If rounding carries out, shift right and increment the exponent.
  - Pack {0, exp, root[ManWidth-1:0]} into Result_o. Pulse ResultVal_o for one cycle, clear Busy_o, return to IDLE.
- Latency: sampling edge at t=0 gives ResultVal_o high in the cycle after edge t = N+1 = ManWidth+3 (26 for default parameters).
- Earliest next accept is edge ManWidth+4 (27); Val_i in the ResultVal_o cycle is accepted.
- Special cases: classified at capture, bypass the arithmetic, but keep identical latency and handshake.
  - Exp=0 (zero or denormal) gives signed zero: +0 -> +0, -0 -> -0, denormals flushed to zero.
  - +Inf gives +Inf.
  - Any NaN, or a negative nonzero non-NaN operand, gives canonical quiet NaN {0, all-ones exp, 1, zeros}. For default parameters this is 0x7FC00000.
- No exponent overflow or underflow is possible for normal inputs; no flags are exported.
- Val_i pulses arriving while Busy_o=1 are dropped silently. Upstream must respect Busy_o.
- Reset asserted mid-CALC or mid-ROUND aborts immediately; the next Val_i after release is processed normally.

Test Plan:
1. Data_i=0x40800000 (4.0), Val_i pulse at edge 0 -> ResultVal_o high for exactly one cycle after edge 26, Result_o=0x40000000; Busy_o high from edge 0 until edge 26.
2. Odd exponent and rounding:
   - 0x40000000 (2.0) -> 0x3FB504F3.
   - 0x41100000 (9.0) -> 0x40400000.
   - 0x41C80000 (25.0) -> 0x40A00000.
   - 0x3E800000 (0.25) -> 0x3F000000.
3. Specials:
   - 0x00000000 -> 0x00000000.
   - 0x80000000 -> 0x80000000.
   - 0x00000001 -> 0x00000000.
   - 0x7F800000 -> 0x7F800000.
   - 0xC0800000 -> 0x7FC00000.
   - 0x7FA00001 -> 0x7FC00000.
   - Each result arrives at latency 26.
4. Val_i held high with Data_i changing every cycle -> accepts at edges 0, 27, 54. Results correspond to the operands present at exactly those edges; all other operands are dropped.
5. Reset asserted 10 cycles after accept, held 2 cycles -> Result_o=0, Busy_o=0, ResultVal_o=0 immediately, and no pulse later. Then Data_i=0x41100000 -> 0x40400000 at latency 26.
6. Random positive normal operands (≥1000) vs. a reference model's correctly rounded sqrtf -> bit-exact match. Result_o remains stable between pulses.
